// File: rtl/idu_pkg.sv
// Shared types and the combinational RV32I/E decoder for the IDU pipeline stage.
// Decoder yields a compact opcode, immediate and operand-use flags.
package idu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [OP_W-1:0] {
    OP_NOP, OP_ILLEGAL,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK, OP_CSRRW, OP_CSRRS
  } op_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_CSR, IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     imm = {inst[31:12], 12'b0};
      IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_SHAMT: imm = {27'b0, inst[24:20]};
      IMM_CSR:   imm = {20'b0, inst[31:20]};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

  // Format/operand usage is set per opcode class, then the exact op is resolved.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t     d;
    imm_fmt_e fmt;
    d         = '0;
    d.op      = OP_ILLEGAL;
    fmt       = IMM_NONE;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin fmt = IMM_U; d.use_rd = 1'b1; end
      OPC_JAL:            begin fmt = IMM_J; d.use_rd = 1'b1; end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        fmt = IMM_I; d.use_rs1 = 1'b1; d.use_rd = 1'b1;
      end
      OPC_BRANCH: begin fmt = IMM_B; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      OPC_STORE:  begin fmt = IMM_S; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      OPC_OP:     begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.use_rd = 1'b1; end
      OPC_SYSTEM: begin fmt = IMM_CSR; d.use_rs1 = 1'b1; d.use_rd = 1'b1; end
      default: ;
    endcase

    casez ({inst[31:25], inst[14:12], inst[6:0]})
      {7'b?, 3'b?,   OPC_LUI}:    d.op = OP_LUI;
      {7'b?, 3'b?,   OPC_AUIPC}:  d.op = OP_AUIPC;
      {7'b?, 3'b?,   OPC_JAL}:    d.op = OP_JAL;
      {7'b?, 3'b000, OPC_JALR}:   d.op = OP_JALR;
      {7'b?, 3'b000, OPC_BRANCH}: d.op = OP_BEQ;
      {7'b?, 3'b001, OPC_BRANCH}: d.op = OP_BNE;
      {7'b?, 3'b100, OPC_BRANCH}: d.op = OP_BLT;
      {7'b?, 3'b101, OPC_BRANCH}: d.op = OP_BGE;
      {7'b?, 3'b110, OPC_BRANCH}: d.op = OP_BLTU;
      {7'b?, 3'b111, OPC_BRANCH}: d.op = OP_BGEU;
      {7'b?, 3'b000, OPC_LOAD}:   d.op = OP_LB;
      {7'b?, 3'b001, OPC_LOAD}:   d.op = OP_LH;
      {7'b?, 3'b010, OPC_LOAD}:   d.op = OP_LW;
      {7'b?, 3'b100, OPC_LOAD}:   d.op = OP_LBU;
      {7'b?, 3'b101, OPC_LOAD}:   d.op = OP_LHU;
      {7'b?, 3'b000, OPC_STORE}:  d.op = OP_SB;
      {7'b?, 3'b001, OPC_STORE}:  d.op = OP_SH;
      {7'b?, 3'b010, OPC_STORE}:  d.op = OP_SW;
      {7'b?, 3'b000, OPC_OPIMM}:  d.op = OP_ADDI;
      {7'b?, 3'b010, OPC_OPIMM}:  d.op = OP_SLTI;
      {7'b?, 3'b011, OPC_OPIMM}:  d.op = OP_SLTIU;
      {7'b?, 3'b100, OPC_OPIMM}:  d.op = OP_XORI;
      {7'b?, 3'b110, OPC_OPIMM}:  d.op = OP_ORI;
      {7'b?, 3'b111, OPC_OPIMM}:  d.op = OP_ANDI;
      {7'b0000000, 3'b001, OPC_OPIMM}: d.op = OP_SLLI;
      {7'b0000000, 3'b101, OPC_OPIMM}: d.op = OP_SRLI;
      {7'b0100000, 3'b101, OPC_OPIMM}: d.op = OP_SRAI;
      {7'b0000000, 3'b000, OPC_OP}: d.op = OP_ADD;
      {7'b0100000, 3'b000, OPC_OP}: d.op = OP_SUB;
      {7'b0000000, 3'b001, OPC_OP}: d.op = OP_SLL;
      {7'b0000000, 3'b010, OPC_OP}: d.op = OP_SLT;
      {7'b0000000, 3'b011, OPC_OP}: d.op = OP_SLTU;
      {7'b0000000, 3'b100, OPC_OP}: d.op = OP_XOR;
      {7'b0000000, 3'b101, OPC_OP}: d.op = OP_SRL;
      {7'b0100000, 3'b101, OPC_OP}: d.op = OP_SRA;
      {7'b0000000, 3'b110, OPC_OP}: d.op = OP_OR;
      {7'b0000000, 3'b111, OPC_OP}: d.op = OP_AND;
      {7'b?, 3'b000, OPC_MISC}:   d.op = OP_FENCE;
      {7'b?, 3'b000, OPC_SYSTEM}: begin
        if (inst == 32'h0000_0073)      d.op = OP_ECALL;
        else if (inst == 32'h0010_0073) d.op = OP_EBREAK;
      end
      {7'b?, 3'b001, OPC_SYSTEM}: d.op = OP_CSRRW;
      {7'b?, 3'b010, OPC_SYSTEM}: d.op = OP_CSRRS;
      default: ;
    endcase

    if (d.op == OP_SLLI || d.op == OP_SRLI || d.op == OP_SRAI) fmt = IMM_SHAMT;
    // ecall/ebreak carry no operands despite sharing the SYSTEM opcode.
    if (d.op == OP_ECALL || d.op == OP_EBREAK || d.op == OP_ILLEGAL) begin
      fmt       = IMM_NONE;
      d.use_rs1 = 1'b0;
      d.use_rs2 = 1'b0;
      d.use_rd  = 1'b0;
    end
    d.illegal = (d.op == OP_ILLEGAL);
    d.imm     = gen_imm(inst, fmt);
    return d;
  endfunction

endpackage

// File: rtl/idu_regfile.sv
// Architectural register file: two combinational read ports with write-back
// bypass, one write port, x0 hardwired to zero.
module idu_regfile
  import idu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NR_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1_c,
  output logic [XLEN-1:0] rdata2_c,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);
  localparam int unsigned AW    = $clog2(NR_REGS);
  localparam int unsigned IDX_W = 6;

  logic [XLEN-1:0] regs [NR_REGS];

  function automatic logic in_range(input logic [4:0] a);
    return IDX_W'(a) < IDX_W'(NR_REGS);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NR_REGS; i++) regs[i] <= '0;
    end else if (wen && waddr != '0 && in_range(waddr)) begin
      regs[AW'(waddr)] <= wdata;
    end
  end

  // Out-of-range indices read as zero; the decoder flags them illegal anyway.
  always_comb begin
    rdata1_c = '0;
    rdata2_c = '0;
    if (raddr1 != '0 && in_range(raddr1))
      rdata1_c = (wen && waddr == raddr1) ? wdata : regs[AW'(raddr1)];
    if (raddr2 != '0 && in_range(raddr2))
      rdata2_c = (wen && waddr == raddr2) ? wdata : regs[AW'(raddr2)];
  end

endmodule

// File: rtl/idu_pipe_stage.sv
// Registered instruction-decode stage between IFU and EXU with a busy-bit
// scoreboard that stalls RAW/WAW hazards through valid/ready handshakes.
module idu_pipe_stage
  import idu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NR_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_op,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);
  localparam int unsigned IDX_W = 6;

  dec_t               dec;
  logic [4:0]         rs1, rs2, rd;
  logic               idx_bad, illegal_c, rd_wen_c, hazard, accept;
  logic [XLEN-1:0]    rdata1, rdata2;
  logic [31:0]        wb_clr32, set32, flush_clr32, busy_eff32;
  logic [NR_REGS-1:0] busy, busy_n;

  idu_regfile #(.XLEN(XLEN), .NR_REGS(NR_REGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rdata1),
    .rdata2_c (rdata2),
    .wen      (wb_valid),
    .waddr    (wb_rd),
    .wdata    (wb_data)
  );

  // Decode, legality against NR_REGS, and hazard detection on the incoming word.
  always_comb begin
    dec       = decode(in_inst);
    rs1       = in_inst[19:15];
    rs2       = in_inst[24:20];
    rd        = in_inst[11:7];
    idx_bad   = (dec.use_rs1 && IDX_W'(rs1) >= IDX_W'(NR_REGS)) ||
                (dec.use_rs2 && IDX_W'(rs2) >= IDX_W'(NR_REGS)) ||
                (dec.use_rd  && IDX_W'(rd)  >= IDX_W'(NR_REGS));
    illegal_c = dec.illegal || idx_bad;
    rd_wen_c  = dec.use_rd && rd != '0 && !illegal_c;

    wb_clr32   = wb_valid ? (32'd1 << wb_rd) : '0;
    busy_eff32 = 32'(busy & ~NR_REGS'(wb_clr32));
    hazard     = !illegal_c &&
                 ((dec.use_rs1 && rs1 != '0 && busy_eff32[rs1]) ||
                  (dec.use_rs2 && rs2 != '0 && busy_eff32[rs2]) ||
                  (rd_wen_c && busy_eff32[rd]));

    in_ready = (!out_valid || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  // Set wins over a same-cycle write-back clear; flush frees only the held rd.
  always_comb begin
    set32       = (accept && rd_wen_c) ? (32'd1 << rd) : '0;
    flush_clr32 = (flush && out_valid && out_rd_wen) ? (32'd1 << out_rd) : '0;
    busy_n      = (busy & ~NR_REGS'(wb_clr32) & ~NR_REGS'(flush_clr32)) | NR_REGS'(set32);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      out_valid    <= 1'b0;
      out_op       <= OP_NOP;
      out_imm      <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_rd_wen   <= 1'b0;
      out_pc       <= '0;
      out_illegal  <= 1'b0;
    end else begin
      busy <= busy_n;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        out_op       <= illegal_c ? OP_ILLEGAL : dec.op;
        out_imm      <= XLEN'($signed(dec.imm));
        out_rs1_data <= dec.use_rs1 ? rdata1 : '0;
        out_rs2_data <= dec.use_rs2 ? rdata2 : '0;
        out_rd       <= dec.use_rd ? rd : '0;
        out_rd_wen   <= rd_wen_c;
        out_pc       <= in_pc;
        out_illegal  <= illegal_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idu_pipe_stage.sv
// Directed scoreboard bench for idu_pipe_stage (RV32I instance plus an RV32E instance).
module tb_idu_pipe_stage;
  import idu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, out_rd_wen, out_illegal;
  logic        wb_valid, flush;
  logic [31:0] in_inst, in_pc, out_imm, out_rs1_data, out_rs2_data, out_pc, wb_data;
  logic [5:0]  out_op;
  logic [4:0]  out_rd, wb_rd;

  logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_out_rd_wen, e_out_illegal;
  logic [31:0] e_in_inst, e_out_imm, e_out_rs1_data, e_out_rs2_data, e_out_pc;
  logic [5:0]  e_out_op;
  logic [4:0]  e_out_rd;

  idu_pipe_stage #(.XLEN(32), .NR_REGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_pc(out_pc), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  idu_pipe_stage #(.XLEN(32), .NR_REGS(16)) dut_e (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_inst(e_in_inst),
    .in_pc(32'h0), .out_valid(e_out_valid), .out_ready(e_out_ready), .out_op(e_out_op),
    .out_imm(e_out_imm), .out_rs1_data(e_out_rs1_data), .out_rs2_data(e_out_rs2_data),
    .out_rd(e_out_rd), .out_rd_wen(e_out_rd_wen), .out_pc(e_out_pc), .out_illegal(e_out_illegal),
    .wb_valid(1'b0), .wb_rd(5'd0), .wb_data(32'h0), .flush(1'b0)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] imm, rs1d, rs2d, pc;
    logic [4:0]  rd;
    logic        wen, ill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input op_e op, input logic [31:0] imm, input logic [31:0] rs1d,
                              input logic [31:0] rs2d, input logic [4:0] rd, input logic wen,
                              input logic [31:0] pc);
    exp_t e;
    e.op = op; e.imm = imm; e.rs1d = rs1d; e.rs2d = rs2d;
    e.rd = rd; e.wen = wen; e.pc = pc; e.ill = (op == OP_ILLEGAL);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL unexpected_issue observed_pc=%h expected=none", out_pc);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk($sformatf("op@%h", e.pc),      32'(out_op),       32'(e.op));
      chk($sformatf("imm@%h", e.pc),     out_imm,           e.imm);
      chk($sformatf("rs1@%h", e.pc),     out_rs1_data,      e.rs1d);
      chk($sformatf("rs2@%h", e.pc),     out_rs2_data,      e.rs2d);
      chk($sformatf("rd@%h", e.pc),      32'(out_rd),       32'(e.rd));
      chk($sformatf("rd_wen@%h", e.pc),  32'(out_rd_wen),   32'(e.wen));
      chk($sformatf("illegal@%h", e.pc), 32'(out_illegal),  32'(e.ill));
      chk($sformatf("pc@%h", e.pc),      out_pc,            e.pc);
    end
  endtask

  // One cycle: compare any output transfer, record any accepted input, advance.
  task automatic tick(input exp_t e);
    #1;
    if (out_valid && out_ready) check_out();
    if (in_valid && in_ready) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    exp_t        none, e;
    logic [31:0] b_inst [6];
    exp_t        b_exp  [6];

    none = mk(OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; flush = 1'b0;
    e_in_valid = 1'b0; e_in_inst = 32'h0; e_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'(OP_NOP));
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_rs1", out_rs1_data, 32'h0);
    chk("rst_out_rd_wen", 32'(out_rd_wen), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_e_out_valid", 32'(e_out_valid), 32'd0);
    @(negedge clk);

    // RV32E instance: x20 is out of range and must not touch busy bits.
    e_out_ready = 1'b1; e_in_valid = 1'b1; e_in_inst = 32'h00100A13;
    @(negedge clk);
    e_in_inst = 32'h00120213;
    #1;
    chk("e_ill_valid", 32'(e_out_valid), 32'd1);
    chk("e_ill_flag", 32'(e_out_illegal), 32'd1);
    chk("e_ill_rd_wen", 32'(e_out_rd_wen), 32'd0);
    chk("e_ill_op", 32'(e_out_op), 32'(OP_ILLEGAL));
    chk("e_ready_after_ill", 32'(e_in_ready), 32'd1);
    @(negedge clk);
    e_in_valid = 1'b0;
    #1;
    chk("e_legal_valid", 32'(e_out_valid), 32'd1);
    chk("e_legal_ill", 32'(e_out_illegal), 32'd0);
    chk("e_legal_wen", 32'(e_out_rd_wen), 32'd1);
    chk("e_legal_imm", e_out_imm, 32'h1);
    @(negedge clk);

    // addi x1,x0,5 then add x2,x1,x1: RAW stall until write-back bypass.
    out_ready = 1'b1;
    drive(32'h00500093, 32'h100);
    tick(mk(OP_ADDI, 32'h5, 32'h0, 32'h0, 5'd1, 1'b1, 32'h100));
    e = mk(OP_ADD, 32'h0, 32'h5, 32'h5, 5'd2, 1'b1, 32'h104);
    drive(32'h00108133, 32'h104);
    #1 chk("raw_stall_ready", 32'(in_ready), 32'd0);
    tick(e);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h5;
    #1 chk("raw_bypass_ready", 32'(in_ready), 32'd1);
    tick(e);
    wb_valid = 1'b0;

    // addi x2,x0,3 while x2 in flight: WAW stall, then set wins over clear.
    e = mk(OP_ADDI, 32'h3, 32'h0, 32'h0, 5'd2, 1'b1, 32'h108);
    drive(32'h00300113, 32'h108);
    #1 chk("waw_stall_ready", 32'(in_ready), 32'd0);
    tick(e);
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'hA;
    #1 chk("waw_release_ready", 32'(in_ready), 32'd1);
    tick(e);
    wb_valid = 1'b0;
    e = mk(OP_ADD, 32'h0, 32'h3, 32'h0, 5'd11, 1'b1, 32'h10C);
    drive(32'h000105B3, 32'h10C);
    #1 chk("set_wins_stall", 32'(in_ready), 32'd0);
    tick(e);
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h3;
    #1 chk("set_wins_release", 32'(in_ready), 32'd1);
    tick(e);
    wb_valid = 1'b0;

    // lui x3,0x12345 held under backpressure for three cycles.
    drive(32'h123451B7, 32'h110);
    tick(mk(OP_LUI, 32'h12345000, 32'h0, 32'h0, 5'd3, 1'b1, 32'h110));
    out_ready = 1'b0;
    e = mk(OP_ADDI, 32'h7, 32'h0, 32'h0, 5'd4, 1'b1, 32'h114);
    drive(32'h00700213, 32'h114);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_op", 32'(out_op), 32'(OP_LUI));
      chk("hold_imm", out_imm, 32'h12345000);
      chk("hold_rd", 32'(out_rd), 32'd3);
      chk("hold_pc", out_pc, 32'h110);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      tick(e);
    end
    out_ready = 1'b1;
    tick(e);

    // jal x1,+8 held, then flushed: x1 must be free for the next instruction.
    drive(32'h008000EF, 32'h118);
    tick(mk(OP_JAL, 32'h8, 32'h0, 32'h0, 5'd1, 1'b1, 32'h118));
    out_ready = 1'b0; in_valid = 1'b0;
    tick(none);
    #1;
    chk("jal_held_valid", 32'(out_valid), 32'd1);
    chk("jal_held_op", 32'(out_op), 32'(OP_JAL));
    e = mk(OP_ADD, 32'h0, 32'h5, 32'h0, 5'd5, 1'b1, 32'h11C);
    flush = 1'b1;
    drive(32'h000082B3, 32'h11C);
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    if (q.size() != 0) void'(q.pop_front());
    tick(e);
    flush = 1'b0;
    #1;
    chk("flush_clears_valid", 32'(out_valid), 32'd0);
    chk("after_flush_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick(e);

    // Back-to-back independent issue, first with a write-back to x0 in flight.
    b_inst[0] = 32'hFFF00313; b_exp[0] = mk(OP_ADDI, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd6, 1'b1, 32'h120);
    b_inst[1] = 32'h00102223; b_exp[1] = mk(OP_SW, 32'h4, 32'h0, 32'h5, 5'd0, 1'b0, 32'h124);
    b_inst[2] = 32'h4030D413; b_exp[2] = mk(OP_SRAI, 32'h3, 32'h5, 32'h0, 5'd8, 1'b1, 32'h128);
    b_inst[3] = 32'hFE008EE3; b_exp[3] = mk(OP_BEQ, 32'hFFFFFFFC, 32'h5, 32'h0, 5'd0, 1'b0, 32'h12C);
    b_inst[4] = 32'h00000073; b_exp[4] = mk(OP_ECALL, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h130);
    b_inst[5] = 32'h00000000; b_exp[5] = mk(OP_ILLEGAL, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h134);
    for (int i = 0; i < 6; i++) begin
      wb_valid = (i == 0); wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
      drive(b_inst[i], b_exp[i].pc);
      #1;
      chk($sformatf("b2b_ready_%0d", i), 32'(in_ready), 32'd1);
      if (i > 0) chk($sformatf("b2b_valid_%0d", i), 32'(out_valid), 32'd1);
      tick(b_exp[i]);
    end
    wb_valid = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4 && q.size() != 0; k++) tick(none);
    chk("drain_empty", 32'(q.size()), 32'd0);

    // Reset while stalled: held op dropped, pending write-back ignored.
    out_ready = 1'b0;
    drive(32'h00008633, 32'h200);
    tick(mk(OP_ADD, 32'h0, 32'h5, 32'h0, 5'd12, 1'b1, 32'h200));
    rst = 1'b1; in_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h77;
    @(negedge clk);
    rst = 1'b0; wb_valid = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_op", 32'(out_op), 32'(OP_NOP));
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(32'h000082B3, 32'h204);
    tick(mk(OP_ADD, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h204));
    in_valid = 1'b0;
    for (int k = 0; k < 4 && q.size() != 0; k++) tick(none);
    chk("final_drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
